// File: rtl/arith_writeback.sv
`default_nettype none
// ============================================================================
// Module   : arith_writeback
// Purpose  : Writeback stage after the arithmetic block. Buffers up to two
//            results in order, retires them to the register-file write port
//            with a valid/ready handshake, commits add/sub flags on retire,
//            and exposes the youngest in-flight result for forwarding.
// Ports    : clk, rst_n (synchronous, active-low)
//            in_valid/in_ready, in_data, in_flags {carry,overflow},
//            in_ctrl, in_addr                      - upstream result
//            wb_valid/wb_ready, wb_addr, wb_data   - register-file port
//            flag_reg                              - committed flags
//            fwd_valid, fwd_addr, fwd_data         - youngest entry
// Revision : 1.0  initial release
// ============================================================================
module arith_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_flags,
    input  logic [2:0]        in_ctrl,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic [1:0]        flag_reg,
    output logic              fwd_valid,
    output logic [ADDR_W-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data
);

    // Queue storage (contents are don't-care after reset, so no reset here)
    logic [DATA_W-1:0] data_q   [2];
    logic [DATA_W-1:0] data_d   [2];
    logic [1:0]        flags_q  [2];
    logic [1:0]        flags_d  [2];
    logic              addsub_q [2];
    logic              addsub_d [2];
    logic [ADDR_W-1:0] addr_q   [2];
    logic [ADDR_W-1:0] addr_d   [2];

    // Control state
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic [1:0] flag_reg_q, flag_reg_d;

    logic w_push;
    logic w_enq;
    logic w_pop;
    logic w_nonempty;
    logic w_youngest;

    always_comb begin
        w_nonempty = (count_q != 2'd0);
        in_ready   = (count_q != 2'd2);
        w_push     = in_valid && in_ready;
        // ctrl 3'b000/3'b001 complete the handshake but are dropped; all
        // other codes carry a result (bit 1 set marks the add/sub group).
        w_enq      = w_push && (in_ctrl[2] || in_ctrl[1]);
        w_pop      = w_nonempty && wb_ready;
        w_youngest = tail_q - 1'b1;

        wb_valid  = w_nonempty;
        fwd_valid = w_nonempty;
        wb_addr   = w_nonempty ? addr_q[head_q]     : '0;
        wb_data   = w_nonempty ? data_q[head_q]     : '0;
        fwd_addr  = w_nonempty ? addr_q[w_youngest] : '0;
        fwd_data  = w_nonempty ? data_q[w_youngest] : '0;
        flag_reg  = flag_reg_q;
    end

    always_comb begin
        data_d     = data_q;
        flags_d    = flags_q;
        addsub_d   = addsub_q;
        addr_d     = addr_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        flag_reg_d = flag_reg_q;

        if (w_enq) begin
            data_d[tail_q]   = in_data;
            flags_d[tail_q]  = in_flags;
            addsub_d[tail_q] = in_ctrl[1];
            addr_d[tail_q]   = in_addr;
            tail_d           = tail_q + 1'b1;
        end

        if (w_pop) begin
            head_d = head_q + 1'b1;
            if (addsub_q[head_q]) begin
                flag_reg_d = flags_q[head_q];
            end
        end

        // Simultaneous enqueue and pop leaves the occupancy unchanged
        count_d = count_q + {1'b0, w_enq} - {1'b0, w_pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            flag_reg_q <= 2'b00;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            flag_reg_q <= flag_reg_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q   <= data_d;
        flags_q  <= flags_d;
        addsub_q <= addsub_d;
        addr_q   <= addr_d;
    end

endmodule
`default_nettype wire

// File: tb/tb_arith_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_writeback
// Purpose  : Self-checking bench for arith_writeback: directed scenarios
//            followed by randomized traffic against a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_arith_writeback;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [1:0]        in_flags;
    logic [2:0]        in_ctrl;
    logic [ADDR_W-1:0] in_addr;
    logic              wb_valid;
    logic              wb_ready;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [1:0]        flag_reg;
    logic              fwd_valid;
    logic [ADDR_W-1:0] fwd_addr;
    logic [DATA_W-1:0] fwd_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    arith_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_flags(in_flags), .in_ctrl(in_ctrl), .in_addr(in_addr),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr),
        .wb_data(wb_data), .flag_reg(flag_reg),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
    );

    // Reference model: an in-order list of pending results plus the flags
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [1:0]        flags;
        logic              addsub;
    } entry_t;

    entry_t     m_q[$];
    logic [1:0] m_flag = 2'b00;

    // Advance one clock; the model applies the documented rules at the edge
    task automatic step();
        bit     acc;
        bit     ret;
        entry_t e;
        acc = in_valid && (m_q.size() < 2);
        ret = wb_ready && (m_q.size() > 0);
        @(posedge clk);
        if (!rst_n) begin
            m_q.delete();
            m_flag = 2'b00;
        end else begin
            if (ret) begin
                e = m_q.pop_front();
                if (e.addsub) m_flag = e.flags;
            end
            if (acc) begin
                e.addr = in_addr; e.data = in_data; e.flags = in_flags;
                case (in_ctrl)
                    3'b010, 3'b011, 3'b110, 3'b111: begin e.addsub = 1'b1; m_q.push_back(e); end
                    3'b100, 3'b101:                 begin e.addsub = 1'b0; m_q.push_back(e); end
                    default: ;
                endcase
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] c, input logic [DATA_W-1:0] d,
                         input logic [1:0] f, input logic [ADDR_W-1:0] a);
        in_valid = v; in_ctrl = c; in_data = d; in_flags = f; in_addr = a;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wb_ready = 1'b0;
        drive(1'b0, 3'b000, '0, 2'b00, '0);
        step(); step();
        rst_n = 1'b1;
        checks++;
        if ({in_ready, wb_valid, fwd_valid, flag_reg} !== 5'b10000) begin
            failures++;
            $display("FAIL reset_ctrl: got rdy=%b wbv=%b fwv=%b flag=%b expected rdy=1 wbv=0 fwv=0 flag=00",
                     in_ready, wb_valid, fwd_valid, flag_reg);
        end
        checks++;
        if (wb_addr !== '0 || wb_data !== '0 || fwd_addr !== '0 || fwd_data !== '0) begin
            failures++;
            $display("FAIL reset_data: got wba=%0h wbd=%0h fwa=%0h fwd=%0h expected all 0",
                     wb_addr, wb_data, fwd_addr, fwd_data);
        end
    endtask

    task automatic test_addsub_retire();
        wb_ready = 1'b1;
        drive(1'b1, 3'b010, 32'h0000_0005, 2'b10, 4'd3);
        step();
        drive(1'b0, 3'b000, '0, 2'b00, '0);
        checks++;
        if (wb_valid !== 1'b1 || wb_addr !== 4'd3 || wb_data !== 32'h5 || fwd_addr !== 4'd3) begin
            failures++;
            $display("FAIL add_head: got v=%b a=%0d d=%0h fa=%0d expected v=1 a=3 d=5 fa=3",
                     wb_valid, wb_addr, wb_data, fwd_addr);
        end
        checks++;
        if (flag_reg !== 2'b00) begin
            failures++;
            $display("FAIL add_flag_early: got %b expected 00", flag_reg);
        end
        step();
        checks++;
        if (flag_reg !== 2'b10 || wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL add_flag_commit: got flag=%b v=%b expected flag=10 v=0", flag_reg, wb_valid);
        end
    endtask

    task automatic test_asl_flags();
        wb_ready = 1'b1;
        drive(1'b1, 3'b100, 32'hDEAD_BEEF, 2'b11, 4'd7);
        step();
        drive(1'b0, 3'b000, '0, 2'b00, '0);
        checks++;
        if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || wb_addr !== 4'd7) begin
            failures++;
            $display("FAIL asl_head: got v=%b a=%0d d=%0h expected v=1 a=7 d=deadbeef",
                     wb_valid, wb_addr, wb_data);
        end
        step();
        checks++;
        if (flag_reg !== 2'b10 || wb_valid !== 1'b0) begin
            failures++;
            $display("FAIL asl_flag_hold: got flag=%b v=%b expected flag=10 v=0", flag_reg, wb_valid);
        end
    endtask

    task automatic test_stall();
        wb_ready = 1'b0;
        drive(1'b1, 3'b110, 32'h0000_00AA, 2'b01, 4'd1);
        step();
        checks++;
        if (in_ready !== 1'b1 || wb_addr !== 4'd1) begin
            failures++;
            $display("FAIL stall_one: got rdy=%b wba=%0d expected rdy=1 wba=1", in_ready, wb_addr);
        end
        drive(1'b1, 3'b011, 32'h0000_00BB, 2'b11, 4'd2);
        step();
        checks++;
        if (in_ready !== 1'b0 || fwd_addr !== 4'd2 || fwd_data !== 32'hBB || wb_addr !== 4'd1) begin
            failures++;
            $display("FAIL stall_full: got rdy=%b fwa=%0d fwd=%0h wba=%0d expected rdy=0 fwa=2 fwd=bb wba=1",
                     in_ready, fwd_addr, fwd_data, wb_addr);
        end
        // Third offer while full must be ignored
        drive(1'b1, 3'b010, 32'h0000_00CC, 2'b00, 4'd9);
        step();
        drive(1'b0, 3'b000, '0, 2'b00, '0);
        checks++;
        if (in_ready !== 1'b0 || wb_addr !== 4'd1 || wb_data !== 32'hAA || fwd_addr !== 4'd2) begin
            failures++;
            $display("FAIL stall_hold: got rdy=%b wba=%0d wbd=%0h fwa=%0d expected rdy=0 wba=1 wbd=aa fwa=2",
                     in_ready, wb_addr, wb_data, fwd_addr);
        end
        wb_ready = 1'b1;
        step();
        checks++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b1 || wb_addr !== 4'd2 || wb_data !== 32'hBB || flag_reg !== 2'b01) begin
            failures++;
            $display("FAIL stall_pop_a: got rdy=%b v=%b wba=%0d wbd=%0h flag=%b expected rdy=1 v=1 wba=2 wbd=bb flag=01",
                     in_ready, wb_valid, wb_addr, wb_data, flag_reg);
        end
        step();
        checks++;
        if (wb_valid !== 1'b0 || flag_reg !== 2'b11) begin
            failures++;
            $display("FAIL stall_pop_b: got v=%b flag=%b expected v=0 flag=11", wb_valid, flag_reg);
        end
    endtask

    task automatic test_pass_through();
        logic [DATA_W-1:0] d;
        wb_ready = 1'b1;
        drive(1'b1, 3'b101, 32'h1234_0000, 2'b00, 4'd4);
        step();
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            drive(1'b1, (i % 2 == 0) ? 3'b100 : 3'b101, d, 2'b01, 4'(i + 8));
            step();
            checks++;
            if (wb_valid !== 1'b1 || in_ready !== 1'b1 || wb_data !== d || wb_addr !== 4'(i + 8)
                || fwd_addr !== 4'(i + 8)) begin
                failures++;
                $display("FAIL pass_through[%0d]: got v=%b rdy=%b wba=%0d wbd=%0h fwa=%0d expected v=1 rdy=1 wba=%0d wbd=%0h",
                         i, wb_valid, in_ready, wb_addr, wb_data, fwd_addr, i + 8, d);
            end
        end
        drive(1'b0, 3'b000, '0, 2'b00, '0);
        step();
        checks++;
        if (wb_valid !== 1'b0 || flag_reg !== 2'b11) begin
            failures++;
            $display("FAIL pass_drain: got v=%b flag=%b expected v=0 flag=11", wb_valid, flag_reg);
        end
    endtask

    task automatic test_discard();
        wb_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 3'(i), 32'hFFFF_FFFF, 2'b00, 4'd5);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++;
                $display("FAIL discard_ready[%0d]: got %b expected 1", i, in_ready);
            end
            step();
            checks++;
            if (wb_valid !== 1'b0 || fwd_valid !== 1'b0 || flag_reg !== 2'b11) begin
                failures++;
                $display("FAIL discard[%0d]: got v=%b fv=%b flag=%b expected v=0 fv=0 flag=11",
                         i, wb_valid, fwd_valid, flag_reg);
            end
        end
        drive(1'b0, 3'b000, '0, 2'b00, '0);
    endtask

    task automatic test_reset_flush();
        wb_ready = 1'b0;
        drive(1'b1, 3'b010, 32'h0000_0011, 2'b10, 4'd6);
        step();
        drive(1'b1, 3'b111, 32'h0000_0022, 2'b01, 4'd7);
        step();
        checks++;
        if (in_ready !== 1'b0 || wb_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_fill: got rdy=%b v=%b expected rdy=0 v=1", in_ready, wb_valid);
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        drive(1'b0, 3'b000, '0, 2'b00, '0);
        checks++;
        if (wb_valid !== 1'b0 || fwd_valid !== 1'b0 || flag_reg !== 2'b00 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_state: got v=%b fv=%b flag=%b rdy=%b expected v=0 fv=0 flag=00 rdy=1",
                     wb_valid, fwd_valid, flag_reg, in_ready);
        end
        wb_ready = 1'b1;
        step();
        checks++;
        if (wb_valid !== 1'b0 || flag_reg !== 2'b00) begin
            failures++;
            $display("FAIL flush_no_write: got v=%b flag=%b expected v=0 flag=00", wb_valid, flag_reg);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] ea, fa;
        logic [DATA_W-1:0] ed, fd;
        m_q.delete();
        m_flag = 2'b00;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 63) != 0);
            wb_ready = ($urandom_range(0, 2) != 0);
            drive(($urandom_range(0, 3) != 0), 3'($urandom), $urandom, 2'($urandom), 4'($urandom));
            step();
            ea = (m_q.size() > 0) ? m_q[0].addr : '0;
            ed = (m_q.size() > 0) ? m_q[0].data : '0;
            fa = (m_q.size() > 0) ? m_q[m_q.size() - 1].addr : '0;
            fd = (m_q.size() > 0) ? m_q[m_q.size() - 1].data : '0;
            checks++;
            if (in_ready !== (m_q.size() < 2) || wb_valid !== (m_q.size() > 0)
                || fwd_valid !== (m_q.size() > 0) || flag_reg !== m_flag) begin
                failures++;
                $display("FAIL rand_ctrl[%0d]: got rdy=%b v=%b fv=%b flag=%b expected occupancy=%0d flag=%b",
                         i, in_ready, wb_valid, fwd_valid, flag_reg, m_q.size(), m_flag);
            end
            checks++;
            if (wb_addr !== ea || wb_data !== ed || fwd_addr !== fa || fwd_data !== fd) begin
                failures++;
                $display("FAIL rand_data[%0d]: got wba=%0h wbd=%0h fwa=%0h fwd=%0h expected %0h %0h %0h %0h",
                         i, wb_addr, wb_data, fwd_addr, fwd_data, ea, ed, fa, fd);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_addsub_retire();
        test_asl_flags();
        test_stall();
        test_pass_through();
        test_discard();
        test_reset_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arith_writeback.md
# arith_writeback

Writeback stage directly downstream of the arithmetic functional block. It accepts each arithmetic result (`value_out`, `flags`) with its destination register index. Results are buffered in a 2-entry in-order queue and retired to the register-file write port under a valid/ready handshake. Add/sub condition flags are committed to an architectural flag register at retire time. The stage also exposes the youngest in-flight result for operand forwarding.

## Interface
Parameters:
- `DATA_W`, 32, result width; matches the arithmetic block output.
- `ADDR_W`, 4, register index width (16 registers).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  upstream result present this cycle.
- `in_ready`  out  1  stage can accept a result this cycle.
- `in_data`  in  DATA_W  arithmetic `value_out`.
- `in_flags`  in  2  arithmetic flags; [1] = carry, [0] = overflow.
- `in_ctrl`  in  3  arith_control of the producing op.
- `in_addr`  in  ADDR_W  destination register index.
- `wb_valid`  out  1  head entry presented to register file.
- `wb_ready`  in  1  register file accepts head this cycle.
- `wb_addr`  out  ADDR_W  head destination index.
- `wb_data`  out  DATA_W  head result.
- `flag_reg`  out  2  committed flags {carry, overflow}.
- `fwd_valid`  out  1  at least one entry in flight.
- `fwd_addr`  out  ADDR_W  youngest entry destination.
- `fwd_data`  out  DATA_W  youngest entry result.

## Operation
- State:
  - two entries, each holding {data, flags, is_addsub, addr};
  - head pointer (1 bit), tail pointer (1 bit);
  - count 0..2;
  - flag_reg.
- `in_ready` = (count != 2). It depends on registered state only.
- Push = `in_valid && in_ready`. Handling of the pushed op depends on `in_ctrl`:
  - 3'b010, 3'b011, 3'b110, 3'b111 (add/sub): enqueue with is_addsub = 1.
  - 3'b100, 3'b101 (asl/asr): enqueue with is_addsub = 0.
  - 3'b000, 3'b001: accepted (handshake completes) but discarded. No enqueue, no flag change.
- Enqueue writes the entry at the tail, advances the tail, and increments count.
- Pop = `wb_valid && wb_ready`. Pop advances the head and decrements count.
  - If the popped entry has is_addsub = 1, flag_reg takes that entry's flags at the same edge.
  - Otherwise flag_reg holds.
- Simultaneous push (enqueuing) and pop: count unchanged and both pointers advance.
  - At count = 1 this is the pass-through case.
  - At count = 2 a push is impossible because `in_ready` = 0.
- Pointer wrap: 1→0 by natural 1-bit overflow.
- `wb_valid` = (count != 0).
- `wb_addr` / `wb_data` come from the head entry when count != 0; they are 0 when empty.
- `wb_valid` must not drop, and the head must not change, until pop. The order of results out matches the order in.
- `fwd_valid` = (count != 0).
- `fwd_addr` / `fwd_data` come from the entry at tail−1 (the youngest); they are 0 when empty.
- An incoming push is not forwarded in the same cycle.
- No arithmetic is performed here. Data passes through unmodified at full DATA_W.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - count, pointers and flag_reg are cleared to 0;
  - all outputs read 0 except `in_ready` = 1;
  - entry contents are don't-care.
- Reset overrides any push or pop in the same cycle. In-flight entries are dropped with no write and no flag update.
- Latency: a result pushed at edge N is on `wb_*` from cycle N+1. Minimum one cycle; no combinational input→wb path.
- Throughput: one result per cycle while `wb_ready` = 1.
- Stall: with `wb_ready` = 0 for two cycles, the stage fills. `in_ready` falls in the cycle after the second push.
- A flag update is visible on `flag_reg` in the cycle after the pop edge.
- All outputs are combinational functions of registered state only.

## Test plan
- Reset, then push add (ctrl 3'b010, data 32'h0000_0005, flags 2'b10, addr 3) with `wb_ready` = 1:
  - next cycle `wb_valid` = 1, `wb_addr` = 3, `wb_data` = 5;
  - after the pop edge, `flag_reg` = 2'b10.
- Push asl (ctrl 3'b100, flags 2'b11) after flag_reg = 2'b10:
  - result is retired;
  - flag_reg stays 2'b10.
- Hold `wb_ready` = 0 and push A (addr 1) then B (addr 2):
  - `in_ready` = 0 and a third `in_valid` is not accepted;
  - `fwd_addr` = 2;
  - release `wb_ready`: A retires, then B, in order;
  - `in_ready` returns to 1 after the first pop.
- With count = 1, push C and pop simultaneously for 8 cycles:
  - count stays 1 and pointers wrap;
  - each result appears exactly one cycle after its push.
- Push ctrl 3'b000:
  - handshake completes;
  - `wb_valid` stays 0 and flag_reg is unchanged.
- With two entries queued, drive `rst_n` = 0 for one edge:
  - `wb_valid` = 0, `fwd_valid` = 0, flag_reg = 0, `in_ready` = 1;
  - no write occurs.
